// File: rtl/rgb_pwm_capture.sv
// Measures the high-cycle count of the R/G/B PWM lines over a PERIOD-clock window,
// classifies the duty triple into a colour code, and presents it on VALID/ACK.
// Optional macro RGB_CAP_SYNC_EN adds a 2-flop synchronizer on each PWM input.
module rgb_pwm_capture #(
    parameter int PERIOD = 100,
    parameter int HI_TH  = 40,
    parameter int LO_TH  = 10,
    parameter int DW     = 7
) (
    input  logic          CLK,
    input  logic          RESETN,
    input  logic          EN,
    input  logic          PWM_R,
    input  logic          PWM_G,
    input  logic          PWM_B,
    input  logic          ACK,
    output logic [DW-1:0] DUTY_R,
    output logic [DW-1:0] DUTY_G,
    output logic [DW-1:0] DUTY_B,
    output logic [2:0]    COLOR,
    output logic          VALID,
    output logic          OVR
);

    typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;
    typedef enum logic [1:0] {LV_OFF, LV_MID, LV_ON} level_t;

    localparam logic [DW-1:0] WC_LAST = DW'(PERIOD - 1);
    localparam logic [DW-1:0] HI      = DW'(HI_TH);
    localparam logic [DW-1:0] LO      = DW'(LO_TH);

    state_t        state;
    logic [DW-1:0] wc;
    logic [DW-1:0] cnt_r, cnt_g, cnt_b;
    logic [2:0]    smp;
    logic [2:0]    color_next;
    level_t        lv_r, lv_g, lv_b;

`ifdef RGB_CAP_SYNC_EN
    logic [2:0] sync1, sync2;

    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {PWM_R, PWM_G, PWM_B};
            sync2 <= sync1;
        end
    end

    assign smp = sync2;
`else
    assign smp = {PWM_R, PWM_G, PWM_B};
`endif

    function automatic level_t level(input logic [DW-1:0] c);
        if (c >= HI)      return LV_ON;
        else if (c <= LO) return LV_OFF;
        else              return LV_MID;
    endfunction

    always_comb begin
        lv_r = level(cnt_r);
        lv_g = level(cnt_g);
        lv_b = level(cnt_b);
        color_next = 3'd7;
        if (lv_r == LV_OFF && lv_g == LV_OFF && lv_b == LV_OFF)     color_next = 3'd0;
        else if (lv_r == LV_ON && lv_g == LV_OFF && lv_b == LV_OFF) color_next = 3'd1;
        else if (lv_r == LV_OFF && lv_g == LV_ON && lv_b == LV_OFF) color_next = 3'd2;
        else if (lv_r == LV_OFF && lv_g == LV_OFF && lv_b == LV_ON) color_next = 3'd3;
        else if (lv_r == LV_ON && lv_g == LV_OFF && lv_b == LV_ON)  color_next = 3'd4;
        else if (lv_r == LV_MID && lv_g == LV_MID && lv_b == LV_MID) color_next = 3'd5;
        else if (lv_r == LV_ON && lv_g == LV_ON && lv_b == LV_ON)   color_next = 3'd6;
    end

    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            state  <= IDLE;
            wc     <= '0;
            cnt_r  <= '0;
            cnt_g  <= '0;
            cnt_b  <= '0;
            DUTY_R <= '0;
            DUTY_G <= '0;
            DUTY_B <= '0;
            COLOR  <= '0;
            VALID  <= 1'b0;
            OVR    <= 1'b0;
        end else begin
            if (VALID && ACK) begin
                VALID <= 1'b0;
                OVR   <= 1'b0;
            end
            case (state)
                IDLE: begin
                    wc    <= '0;
                    cnt_r <= '0;
                    cnt_g <= '0;
                    cnt_b <= '0;
                    if (EN) state <= MEASURE;
                end
                MEASURE: begin
                    if (!EN) begin
                        // Aborted window: discard partial counts, keep old result.
                        state <= IDLE;
                        wc    <= '0;
                        cnt_r <= '0;
                        cnt_g <= '0;
                        cnt_b <= '0;
                    end else begin
                        cnt_r <= cnt_r + DW'(smp[2]);
                        cnt_g <= cnt_g + DW'(smp[1]);
                        cnt_b <= cnt_b + DW'(smp[0]);
                        if (wc == WC_LAST) begin
                            state <= DONE;
                        end else begin
                            wc <= wc + 1'b1;
                        end
                    end
                end
                DONE: begin
                    DUTY_R <= cnt_r;
                    DUTY_G <= cnt_g;
                    DUTY_B <= cnt_b;
                    COLOR  <= color_next;
                    VALID  <= 1'b1;
                    // A same-cycle ACK consumes the old result, so no overrun.
                    OVR    <= VALID && !ACK ? 1'b1 : (VALID ? 1'b0 : OVR);
                    wc     <= '0;
                    cnt_r  <= '0;
                    cnt_g  <= '0;
                    cnt_b  <= '0;
                    state  <= EN ? MEASURE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_pwm_capture.sv
// Directed bench for rgb_pwm_capture: window counts, colour codes, handshake,
// overrun, abort and asynchronous reset, with hand-computed expectations.
module tb_rgb_pwm_capture;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b1;
    logic       EN = 1'b0;
    logic       PWM_R = 1'b0, PWM_G = 1'b0, PWM_B = 1'b0;
    logic       ACK = 1'b0;
    logic [6:0] DUTY_R, DUTY_G, DUTY_B;
    logic [2:0] COLOR;
    logic       VALID, OVR;

    int total = 0;
    int bad   = 0;

    // table windows, all acknowledged on the DONE cycle
    int tr[6] = '{40,  0,  0, 50, 0, 41};
    int tg[6] = '{40, 40,  0, 50, 0,  9};
    int tb[6] = '{40,  0, 70,  0, 0, 40};
    int tc[6] = '{ 6,  2,  3,  7, 0,  4};

    always #5 CLK = ~CLK;

    rgb_pwm_capture dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .EN     (EN),
        .PWM_R  (PWM_R),
        .PWM_G  (PWM_G),
        .PWM_B  (PWM_B),
        .ACK    (ACK),
        .DUTY_R (DUTY_R),
        .DUTY_G (DUTY_G),
        .DUTY_B (DUTY_B),
        .COLOR  (COLOR),
        .VALID  (VALID),
        .OVR    (OVR)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Called in the first MEASURE cycle; returns in the DONE cycle.
    task automatic run_window(input int nr, input int ng, input int nb, input bit ack_first);
        for (int i = 0; i < 100; i++) begin
            PWM_R = (i < nr);
            PWM_G = (i < ng);
            PWM_B = (i < nb);
            ACK   = ack_first && (i == 0);
            if (ack_first && i == 1) begin
                check("ack_clears_valid", VALID, 0);
                check("ack_clears_ovr", OVR, 0);
            end
            tick();
        end
        PWM_R = 1'b0;
        PWM_G = 1'b0;
        PWM_B = 1'b0;
        ACK   = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_duty_r", DUTY_R, 0);
        check("rst_color", COLOR, 0);
        check("rst_valid", VALID, 0);
        check("rst_ovr", OVR, 0);
        RESETN = 1'b0;
        PWM_R  = 1'b1;
        tick();
        EN = 1'b1;
        tick();

        // R held high for a whole window
        run_window(100, 0, 0, 1'b0);
        check("latency_valid_low", VALID, 0);
        tick();
        check("w1_valid", VALID, 1);
        check("w1_duty_r", DUTY_R, 100);
        check("w1_duty_g", DUTY_G, 0);
        check("w1_duty_b", DUTY_B, 0);
        check("w1_color", COLOR, 1);
        check("w1_ovr", OVR, 0);

        // unacknowledged second result -> overrun
        run_window(33, 33, 33, 1'b0);
        tick();
        check("w2_valid", VALID, 1);
        check("w2_ovr", OVR, 1);
        check("w2_duty_r", DUTY_R, 33);
        check("w2_duty_g", DUTY_G, 33);
        check("w2_duty_b", DUTY_B, 33);
        check("w2_color", COLOR, 5);

        run_window(50, 0, 50, 1'b1);
        tick();
        check("w3_valid", VALID, 1);
        check("w3_ovr", OVR, 0);
        check("w3_duty_r", DUTY_R, 50);
        check("w3_color", COLOR, 4);

        // thresholds at the boundary, overrun again
        run_window(40, 0, 10, 1'b0);
        tick();
        check("w4_ovr", OVR, 1);
        check("w4_duty_b", DUTY_B, 10);
        check("w4_color", COLOR, 1);

        // ACK on the DONE cycle
        run_window(11, 39, 20, 1'b0);
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        check("w5_valid", VALID, 1);
        check("w5_ovr", OVR, 0);
        check("w5_duty_g", DUTY_G, 39);
        check("w5_color", COLOR, 5);

        for (int k = 0; k < 6; k++) begin
            run_window(tr[k], tg[k], tb[k], 1'b0);
            ACK = 1'b1;
            tick();
            ACK = 1'b0;
            check("tbl_color", COLOR, tc[k]);
            check("tbl_duty_r", DUTY_R, tr[k]);
            check("tbl_duty_g", DUTY_G, tg[k]);
            check("tbl_duty_b", DUTY_B, tb[k]);
            check("tbl_ovr", OVR, 0);
        end

        // abort at WC=50
        for (int i = 0; i < 50; i++) begin
            PWM_R = 1'b1;
            ACK   = (i == 0);
            tick();
        end
        ACK = 1'b0;
        EN  = 1'b0;
        tick();
        PWM_R = 1'b0;
        for (int i = 0; i < 110; i++) tick();
        check("abort_valid", VALID, 0);
        check("abort_keep_r", DUTY_R, 41);
        check("abort_keep_g", DUTY_G, 9);
        check("abort_keep_color", COLOR, 4);

        // a fresh window after abort starts from zero
        EN = 1'b1;
        tick();
        run_window(25, 0, 0, 1'b0);
        tick();
        check("restart_valid", VALID, 1);
        check("restart_duty_r", DUTY_R, 25);
        check("restart_color", COLOR, 7);

        // asynchronous reset at WC=30
        for (int i = 0; i < 30; i++) begin
            PWM_G = 1'b1;
            tick();
        end
        RESETN = 1'b1;
        #1;
        check("arst_duty_r", DUTY_R, 0);
        check("arst_color", COLOR, 0);
        check("arst_valid", VALID, 0);
        check("arst_ovr", OVR, 0);
        PWM_G  = 1'b0;
        EN     = 1'b0;
        tick();
        RESETN = 1'b0;
        for (int i = 0; i < 120; i++) tick();
        check("post_rst_valid", VALID, 0);
        check("post_rst_duty_g", DUTY_G, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_capture.md
# rgb_pwm_capture

Receive-side companion to the RGB LED PWM driver. It samples the three 1-bit PWM lines (R, G, B) over a fixed window of PERIOD clocks and counts the high cycles per channel to recover each duty level. It classifies the resulting level triple into a colour code and presents the result on a VALID/ACK handshake. It sits on the LED output pins for self-test and colour-sequence checking.

## Interface
- PERIOD, 100: window length in CLK cycles; one duty count per window; must be ≥ 2.
- HI_TH, 40: a channel is "on" when its duty count is ≥ HI_TH.
- LO_TH, 10: a channel is "off" when its duty count is ≤ LO_TH; requires LO_TH < HI_TH.
- DW, 7: duty-count width, equal to clog2(PERIOD+1).

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RESETN  in  1  reset, asynchronous, active-high.
- EN  in  1  measurement enable (level).
- PWM_R, PWM_G, PWM_B  in  1 each  PWM lines under test.
- DUTY_R, DUTY_G, DUTY_B  out  DW each  high-cycle count of the last completed window.
- COLOR  out  3  classification of the last completed window.
- VALID  out  1  result available, held until acknowledged.
- ACK  in  1  consumer acknowledge; takes effect on any cycle where VALID=1.
- OVR  out  1  sticky overrun flag.

## Operation
- Reset values: state IDLE; window counter 0; all high counters 0; DUTY_* = 0; COLOR = 0; VALID = 0; OVR = 0.
- The FSM has three states: IDLE, MEASURE, DONE.
- **IDLE**
  - Counters are held at 0.
  - EN=1 → MEASURE.
- **MEASURE**
  - Every cycle, the window counter WC increments from 0 to PERIOD-1.
  - Each channel's counter increments when its sampled PWM bit is 1.
  - At WC = PERIOD-1 the state goes to DONE; that cycle's sample is included in the count.
- **DONE** (lasts 1 cycle)
  - Final counts are latched into DUTY_*, COLOR is latched, and VALID is set.
  - Counters and WC are cleared.
  - Next state is MEASURE if EN=1, otherwise IDLE. Windows run back-to-back with a 1-cycle gap.
- **Arithmetic:** a count never exceeds PERIOD, so no saturation is needed. A PWM line held at 1 yields DUTY = PERIOD.
- **Classification.** Each channel is ON (≥ HI_TH), OFF (≤ LO_TH) or MID (otherwise):
  - 0 OFF: all three OFF.
  - 1 RED: R ON, G and B OFF.
  - 2 GREEN: G ON, R and B OFF.
  - 3 BLUE: B ON, R and G OFF.
  - 4 PURPLE: R and B ON, G OFF.
  - 5 GRAY: all three MID.
  - 6 WHITE: all three ON.
  - 7 OTHER: any other combination.
- **Handshake and overrun:**
  - ACK with VALID=1 clears VALID and OVR on the next edge.
  - ACK while VALID=0 is ignored.
  - If DONE occurs while VALID=1 and there is no ACK that cycle, OVR is set and DUTY_*/COLOR are overwritten with the new result.
  - DONE and ACK in the same cycle: VALID stays 1 with the new data, OVR is cleared, and no overrun is flagged.
- **EN deasserted mid-window:** the window is aborted on the next edge. Counters clear, the FSM goes to IDLE, no VALID is produced, and previous outputs are kept.
- **RESETN mid-window:** all state and outputs return to their reset values immediately.

## Timing
- Without the macro, a PWM sample presented on cycle k is counted at edge k.
- The first MEASURE cycle is the cycle after EN is seen high in IDLE.
- VALID rises 1 cycle after the WC = PERIOD-1 cycle, i.e. PERIOD+1 edges after entering MEASURE.
- Steady-state result rate with EN held high is one result every PERIOD+1 cycles.
- All outputs are registered; there is no combinational path from ACK or PWM_* to any output.

## Configuration
- RGB_CAP_SYNC_EN defined:
  - Each PWM_* input passes through a 2-flop synchronizer (flops reset to 0) before counting.
  - Windows count the synchronized samples, which lag the pins by 2 cycles. VALID timing relative to EN is unchanged.
- Not defined: PWM_* are sampled directly by the counters; the inputs must be synchronous to CLK.

## Test plan
- PWM_R=1, PWM_G=PWM_B=0 constant, EN=1, defaults → after 101 cycles VALID=1, DUTY_R=100, DUTY_G=DUTY_B=0, COLOR=1.
- Each channel high 33 of every 100 cycles, aligned to the window → DUTY_*=33, COLOR=5. With R and B at 50 and G at 0 → COLOR=4.
- No ACK across two windows → OVR=1 after the second DONE, DUTY_* show the second window. ACK → VALID=0, OVR=0 next cycle.
- ACK asserted exactly on the DONE cycle → VALID remains 1, data updated, OVR=0.
- EN dropped at WC=50 → no VALID, FSM in IDLE, previous DUTY_* retained. RESETN pulse at WC=30 → all outputs 0 immediately.
- With RGB_CAP_SYNC_EN: PWM_R rises at the window start and falls after 20 cycles → DUTY_R=20, the first 2 window samples read the synchronizer reset value 0.
